// File: rtl/piso_register.sv
// piso_register
// Parallel-in/serial-out transmit register with a one-word holding buffer.
// A word accepted on load is streamed out one bit per clock. A second word
// accepted while the first is still shifting waits in the hold buffer. It is
// then sent back-to-back with no gap in ser_valid.
//
// Parameters
//   WIDTH      word size in bits (>= 2)
//   MSB_FIRST  0 = LSB sent first, 1 = MSB sent first
// Ports
//   clk          rising-edge system clock
//   rst          synchronous active-high reset
//   load         write request, accepted when ready=1
//   data_in      word sampled on an accepted load
//   ready        1 = a load this cycle is accepted
//   ser_out      current serial bit (0 when ser_valid=0)
//   ser_valid    high for every cycle carrying a data bit
//   frame_start  high with the first bit of each word
//   done         one-cycle pulse in the cycle after a word's last bit
module piso_register #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] hold_buf;
  logic             hold_valid;
  logic             accept;
  logic             last_bit;

  // ready decodes only registered state and rst. There is no path from
  // load or data_in, so it is safe to feed back into an upstream handshake.
  assign ready    = ~hold_valid & ~rst;
  assign accept   = load & ready;
  assign last_bit = (bit_cnt == LAST_BIT);

  // The transmit bit always sits at the outgoing end of the shift register.
  // Shift away from that end.
  always_comb begin
    shift_next = shift_reg;
    if (MSB_FIRST)
      shift_next = {shift_reg[WIDTH-2:0], 1'b0};
    else
      shift_next = {1'b0, shift_reg[WIDTH-1:1]};
  end

  // On the last-bit edge, a held word has priority over a fresh load.
  // That cannot collide with a fresh load: while the hold buffer is full,
  // ready is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      hold_buf   <= '0;
      hold_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            done <= 1'b1;
            if (hold_valid) begin
              shift_reg  <= hold_buf;
              hold_valid <= 1'b0;
              bit_cnt    <= '0;
            end else if (accept) begin
              shift_reg <= data_in;
              bit_cnt   <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + CW'(1);
            if (accept) begin
              hold_buf   <= data_in;
              hold_valid <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The serial outputs are decoded purely from registered state. That makes
  // them glitch-free and forces them to 0 whenever the FSM is not shifting.
  assign ser_valid   = (state == ST_SHIFT);
  assign ser_out     = ser_valid & (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
  assign frame_start = ser_valid & (bit_cnt == '0);

endmodule

// File: tb/tb_piso_register.sv
// tb_piso_register
// Drives an LSB-first and an MSB-first instance of piso_register with the
// same stimulus. It checks both against a directed vector table, and against
// a timeline model that schedules each accepted word's bits, frame_start and
// done pulse into per-cycle expectation arrays.
module tb_piso_register;

  localparam int W    = 8;
  localparam int NCYC = 4096;

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] data;
    logic       e_ready;
    logic       e_lsb;
    logic       e_msb;
    logic       e_valid;
    logic       e_fs;
    logic       e_done;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] data_in;
  logic       ready_l, ser_out_l, ser_valid_l, frame_start_l, done_l;
  logic       ready_m, ser_out_m, ser_valid_m, frame_start_m, done_m;

  int tests_run;
  int tests_failed;
  int cyc;

  // Timeline model state: per-cycle expectations plus the end of the last
  // scheduled word and the window during which the hold buffer is full.
  bit exp_v    [NCYC];
  bit exp_fs   [NCYC];
  bit exp_done [NCYC];
  bit exp_lsb  [NCYC];
  bit exp_msb  [NCYC];
  int last_end;
  int hold_lo;
  int hold_hi;

  vec_t tbl[$];

  piso_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in),
    .ready(ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .frame_start(frame_start_l), .done(done_l)
  );

  piso_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in),
    .ready(ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
    .frame_start(frame_start_m), .done(done_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic l, input logic [7:0] d,
                              input logic rd, input logic sl, input logic sm,
                              input logic v, input logic fs, input logic dn);
    vec_t t;
    t.rst = r; t.load = l; t.data = d; t.e_ready = rd; t.e_lsb = sl;
    t.e_msb = sm; t.e_valid = v; t.e_fs = fs; t.e_done = dn;
    return t;
  endfunction

  task automatic cmp(input string name, input logic act, input logic expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, act, expv);
    end
  endtask

  task automatic checkOutput(input logic rd, input logic sl, input logic sm,
                             input logic v, input logic fs, input logic dn);
    cmp("ready_lsb", ready_l, rd);
    cmp("ready_msb", ready_m, rd);
    cmp("ser_valid_lsb", ser_valid_l, v);
    cmp("ser_valid_msb", ser_valid_m, v);
    cmp("frame_start_lsb", frame_start_l, fs);
    cmp("frame_start_msb", frame_start_m, fs);
    cmp("done_lsb", done_l, dn);
    cmp("done_msb", done_m, dn);
    cmp("ser_out_lsb", ser_out_l, sl);
    cmp("ser_out_msb", ser_out_m, sm);
  endtask

  // One clock cycle: drive inputs just after the rising edge, check on the
  // falling edge, then advance the model with this cycle's accept or reset.
  task automatic applyStimulus(input logic r, input logic l, input logic [7:0] d,
                               input bit use_row, input vec_t row);
    bit model_ready;
    int start;
    rst = r; load = l; data_in = d;
    @(negedge clk);
    model_ready = !r && !(cyc >= hold_lo && cyc <= hold_hi);
    if (use_row)
      checkOutput(row.e_ready, row.e_lsb, row.e_msb, row.e_valid, row.e_fs, row.e_done);
    else
      checkOutput(model_ready, exp_lsb[cyc], exp_msb[cyc], exp_v[cyc],
                  exp_fs[cyc], exp_done[cyc]);
    if (r) begin
      for (int c = cyc + 1; c < NCYC && c <= cyc + 3 * W; c++) begin
        exp_v[c] = 0; exp_fs[c] = 0; exp_done[c] = 0;
        exp_lsb[c] = 0; exp_msb[c] = 0;
      end
      last_end = cyc;
      hold_lo  = 1;
      hold_hi  = 0;
    end else if (l && model_ready) begin
      start = ((last_end > cyc) ? last_end : cyc) + 1;
      if (last_end > cyc) begin
        hold_lo = cyc + 1;
        hold_hi = last_end;
      end
      for (int k = 0; k < W; k++) begin
        exp_v[start + k]   = 1;
        exp_lsb[start + k] = d[k];
        exp_msb[start + k] = d[W - 1 - k];
      end
      exp_fs[start]       = 1;
      exp_done[start + W] = 1;
      last_end = start + W - 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input logic r, input logic l, input logic [7:0] d);
    vec_t none;
    none = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    applyStimulus(r, l, d, 1'b0, none);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; cyc = 0;
    last_end = -100; hold_lo = 1; hold_hi = 0;
    for (int c = 0; c < NCYC; c++) begin
      exp_v[c] = 0; exp_fs[c] = 0; exp_done[c] = 0; exp_lsb[c] = 0; exp_msb[c] = 0;
    end

    // Directed vectors: 0xA5 then 0x01, both bit orders side by side.
    //        rst load data   rdy lsb msb vld fs done
    tbl.push_back(mk(0, 1, 8'hA5, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 0));

    // Power-up reset: the first edge clears state, then reset outputs are checked.
    rst = 1'b1; load = 1'b0; data_in = 8'h00;
    @(posedge clk);
    #1;
    step(1, 0, 8'h00);
    step(1, 1, 8'hFF);

    foreach (tbl[i])
      applyStimulus(tbl[i].rst, tbl[i].load, tbl[i].data, 1'b1, tbl[i]);

    // Back-to-back through the hold buffer, plus refused loads while it is full.
    step(0, 1, 8'h3C);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    step(0, 1, 8'hC3);
    for (int i = 4; i <= 8; i++) step(0, 1, 8'hFF);
    for (int i = 0; i < 12; i++) step(0, 0, 8'h00);

    // Reset mid-word with a second word held; then recovery with 0x81.
    step(0, 1, 8'hFF);
    step(0, 0, 8'h00);
    step(0, 1, 8'h5A);
    step(0, 0, 8'h00);
    step(1, 1, 8'h77);
    step(0, 0, 8'h00);
    step(0, 1, 8'h81);
    for (int i = 0; i < 12; i++) step(0, 0, 8'h00);

    // Last-bit bypass: a fresh load during the last bit, with the hold buffer empty.
    step(0, 1, 8'h55);
    for (int i = 1; i < 8; i++) step(0, 0, 8'h00);
    step(0, 1, 8'h0F);
    for (int i = 0; i < 12; i++) step(0, 0, 8'h00);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      logic       r;
      logic       l;
      logic [7:0] d;
      r = ($urandom % 64) == 0;
      l = ($urandom % 3) == 0;
      d = 8'($urandom);
      step(r, l, d);
    end
    for (int i = 0; i < 12; i++) step(0, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
